// File: rtl/alu_nbit_seq_if.sv
// rtl/alu_nbit_seq_if.sv - request/response handshake bundle for alu_nbit_seq
interface alu_nbit_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, cout, overflow
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, cout, overflow
    );
endinterface

// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - registered ALU with handshake, bit-serial shift and shift-add multiply
module alu_nbit_seq #(
    parameter int WIDTH = 16,
    parameter int SW    = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst_n,
    alu_nbit_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    state_t               state, nxt_state;
    logic [SW-1:0]        cnt, nxt_cnt;
    logic                 shl, nxt_shl;
    logic [WIDTH-1:0]     work, nxt_work;
    logic [WIDTH-1:0]     mplier, nxt_mplier;
    logic [2*WIDTH-1:0]   mcand, nxt_mcand;
    logic [2*WIDTH-1:0]   prod, nxt_prod;
    logic [WIDTH-1:0]     result_q, nxt_result;
    logic                 zero_q, nxt_zero;
    logic                 cout_q, nxt_cout;
    logic                 ovf_q, nxt_ovf;

    logic [WIDTH:0]       sum_add, sum_sub;
    logic                 ovf_add, ovf_sub;
    logic [SW-1:0]        shamt;
    logic [WIDTH-1:0]     first_shift, work_shift;
    logic [2*WIDTH-1:0]   prod_step;

    // Overflow is carry-into-MSB xor carry-out; carry-in is recovered as a^b^sum at the MSB.
    assign shamt       = bus.b[SW-1:0];
    assign sum_add     = {1'b0, bus.a} + {1'b0, bus.b};
    assign sum_sub     = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    assign ovf_add     = bus.a[WIDTH-1] ^ bus.b[WIDTH-1] ^ sum_add[WIDTH-1] ^ sum_add[WIDTH];
    assign ovf_sub     = bus.a[WIDTH-1] ^ ~bus.b[WIDTH-1] ^ sum_sub[WIDTH-1] ^ sum_sub[WIDTH];

    // The first shift step and the first multiply iteration happen on the accept edge,
    // so a shift by N takes N edges and a multiply takes WIDTH edges.
    assign first_shift = (bus.op == OP_SLL) ? {bus.a[WIDTH-2:0], 1'b0} : {1'b0, bus.a[WIDTH-1:1]};
    assign work_shift  = shl ? {work[WIDTH-2:0], 1'b0} : {1'b0, work[WIDTH-1:1]};
    assign prod_step   = mplier[0] ? prod + mcand : prod;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shl      <= 1'b0;
            work     <= '0;
            mplier   <= '0;
            mcand    <= '0;
            prod     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            shl      <= nxt_shl;
            work     <= nxt_work;
            mplier   <= nxt_mplier;
            mcand    <= nxt_mcand;
            prod     <= nxt_prod;
            result_q <= nxt_result;
            zero_q   <= nxt_zero;
            cout_q   <= nxt_cout;
            ovf_q    <= nxt_ovf;
        end
    end

    // Next-state and next-datapath decode; everything holds unless a state acts on it.
    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_shl    = shl;
        nxt_work   = work;
        nxt_mplier = mplier;
        nxt_mcand  = mcand;
        nxt_prod   = prod;
        nxt_result = result_q;
        nxt_zero   = zero_q;
        nxt_cout   = cout_q;
        nxt_ovf    = ovf_q;

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    nxt_cout = 1'b0;
                    nxt_ovf  = 1'b0;
                    case (bus.op)
                        OP_AND: begin
                            nxt_result = bus.a & bus.b;
                            nxt_state  = DONE;
                        end
                        OP_OR: begin
                            nxt_result = bus.a | bus.b;
                            nxt_state  = DONE;
                        end
                        OP_ADD: begin
                            nxt_result = sum_add[WIDTH-1:0];
                            nxt_cout   = sum_add[WIDTH];
                            nxt_ovf    = ovf_add;
                            nxt_state  = DONE;
                        end
                        OP_SUB: begin
                            nxt_result = sum_sub[WIDTH-1:0];
                            nxt_cout   = sum_sub[WIDTH];
                            nxt_ovf    = ovf_sub;
                            nxt_state  = DONE;
                        end
                        OP_SLT: begin
                            nxt_result = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ovf_sub};
                            nxt_state  = DONE;
                        end
                        OP_SLL, OP_SRL: begin
                            nxt_shl = (bus.op == OP_SLL);
                            if (shamt == '0) begin
                                nxt_result = bus.a;
                                nxt_state  = DONE;
                            end else if (shamt == SW'(1)) begin
                                nxt_result = first_shift;
                                nxt_state  = DONE;
                            end else begin
                                nxt_work  = first_shift;
                                nxt_cnt   = shamt - SW'(1);
                                nxt_state = SHIFT;
                            end
                        end
                        default: begin
                            nxt_prod   = bus.b[0] ? {{WIDTH{1'b0}}, bus.a} : '0;
                            nxt_mcand  = {{(WIDTH-1){1'b0}}, bus.a, 1'b0};
                            nxt_mplier = {1'b0, bus.b[WIDTH-1:1]};
                            nxt_cnt    = SW'(WIDTH-1);
                            nxt_state  = MUL;
                        end
                    endcase
                end
            end
            SHIFT: begin
                nxt_work = work_shift;
                nxt_cnt  = cnt - SW'(1);
                if (cnt == SW'(1)) begin
                    nxt_result = work_shift;
                    nxt_state  = DONE;
                end
            end
            MUL: begin
                nxt_prod   = prod_step;
                nxt_mcand  = {mcand[2*WIDTH-2:0], 1'b0};
                nxt_mplier = {1'b0, mplier[WIDTH-1:1]};
                nxt_cnt    = cnt - SW'(1);
                if (cnt == SW'(1)) begin
                    nxt_result = prod_step[WIDTH-1:0];
                    nxt_ovf    = |prod_step[2*WIDTH-1:WIDTH];
                    nxt_state  = DONE;
                end
            end
            default: begin
                if (bus.out_ready) begin
                    nxt_state = IDLE;
                end
            end
        endcase

        // zero always reflects the value being registered as the final result.
        if (nxt_state == DONE && state != DONE) begin
            nxt_zero = (nxt_result == '0);
        end
    end
endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - directed self-checking bench for alu_nbit_seq
module tb_alu_nbit_seq;
    localparam int W = 16;

    localparam logic [2:0] AND_ = 3'b000;
    localparam logic [2:0] OR_  = 3'b001;
    localparam logic [2:0] ADD_ = 3'b010;
    localparam logic [2:0] SUB_ = 3'b011;
    localparam logic [2:0] SLT_ = 3'b100;
    localparam logic [2:0] SLL_ = 3'b101;
    localparam logic [2:0] SRL_ = 3'b110;
    localparam logic [2:0] MUL_ = 3'b111;

    typedef struct packed {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_nbit_seq_if #(.WIDTH(W)) bus ();

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = ~op;
        bus.a        = ~a;
        bus.b        = ~b;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic release_op;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 3'b000;
        bus.a         = '0;
        bus.b         = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.cout, bus.overflow} !==
            {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: got rdy=%b vld=%b res=%h z=%b c=%b v=%b want rdy=1 vld=0 res=0000 z=0 c=0 v=0",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.cout, bus.overflow);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_ops;
        vec_t tv [11];
        int   lat;
        tv = '{
            '{ADD_, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1},
            '{SUB_, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 1},
            '{ADD_, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1},
            '{SUB_, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1},
            '{SUB_, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1},
            '{AND_, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 1},
            '{OR_,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1},
            '{SLT_, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1},
            '{SLT_, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 1},
            '{SLT_, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1},
            '{SLT_, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1}
        };
        for (int i = 0; i < 11; i++) begin
            run_op(tv[i].op, tv[i].a, tv[i].b, lat);
            total++;
            if ({bus.result, bus.zero, bus.cout, bus.overflow} !== {tv[i].res, tv[i].z, tv[i].c, tv[i].v}) begin
                bad++;
                $display("FAIL alu[%0d] op=%b: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b", i, tv[i].op,
                         bus.result, bus.zero, bus.cout, bus.overflow, tv[i].res, tv[i].z, tv[i].c, tv[i].v);
            end
            total++;
            if (lat != tv[i].lat) begin
                bad++;
                $display("FAIL alu_latency[%0d]: got %0d want %0d", i, lat, tv[i].lat);
            end
            release_op;
            total++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                bad++;
                $display("FAIL alu_release[%0d]: got rdy=%b vld=%b want rdy=1 vld=0", i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_shift;
        vec_t tv [6];
        int   lat;
        tv = '{
            '{SLL_, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 15},
            '{SRL_, 16'hF000, 16'h0000, 16'hF000, 1'b0, 1'b0, 1'b0, 1},
            '{SRL_, 16'hF000, 16'h0004, 16'h0F00, 1'b0, 1'b0, 1'b0, 4},
            '{SLL_, 16'h0003, 16'h0001, 16'h0006, 1'b0, 1'b0, 1'b0, 1},
            '{SRL_, 16'h8000, 16'h0013, 16'h1000, 1'b0, 1'b0, 1'b0, 3},
            '{SLL_, 16'hFFFF, 16'h0008, 16'hFF00, 1'b0, 1'b0, 1'b0, 8}
        };
        for (int i = 0; i < 6; i++) begin
            run_op(tv[i].op, tv[i].a, tv[i].b, lat);
            total++;
            if ({bus.result, bus.zero, bus.cout, bus.overflow} !== {tv[i].res, tv[i].z, tv[i].c, tv[i].v}) begin
                bad++;
                $display("FAIL shift[%0d]: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b", i,
                         bus.result, bus.zero, bus.cout, bus.overflow, tv[i].res, tv[i].z, tv[i].c, tv[i].v);
            end
            total++;
            if (lat != tv[i].lat) begin
                bad++;
                $display("FAIL shift_latency[%0d]: got %0d want %0d", i, lat, tv[i].lat);
            end
            release_op;
        end
    endtask

    task automatic test_mul;
        vec_t tv [5];
        int   lat;
        tv = '{
            '{MUL_, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 16},
            '{MUL_, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16},
            '{MUL_, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 16},
            '{MUL_, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16},
            '{MUL_, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 16}
        };
        for (int i = 0; i < 5; i++) begin
            run_op(tv[i].op, tv[i].a, tv[i].b, lat);
            total++;
            if ({bus.result, bus.zero, bus.cout, bus.overflow} !== {tv[i].res, tv[i].z, tv[i].c, tv[i].v}) begin
                bad++;
                $display("FAIL mul[%0d]: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b", i,
                         bus.result, bus.zero, bus.cout, bus.overflow, tv[i].res, tv[i].z, tv[i].c, tv[i].v);
            end
            total++;
            if (lat != tv[i].lat) begin
                bad++;
                $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, tv[i].lat);
            end
            release_op;
        end
    endtask

    task automatic test_back_to_back;
        bus.op       = ADD_;
        bus.a        = 16'h0002;
        bus.b        = 16'h0003;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 16'h0010;
        bus.b = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b0, 16'h0005}) begin
                bad++;
                $display("FAIL hold[%0d]: got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=0005",
                         i, bus.out_valid, bus.in_ready, bus.result);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL hold_release: got rdy=%b vld=%b want rdy=1 vld=0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.result} !== {1'b1, 16'h0030}) begin
            bad++;
            $display("FAIL second_accept: got vld=%b res=%h want vld=1 res=0030", bus.out_valid, bus.result);
        end
        release_op;
    endtask

    task automatic test_reset_mid_mul;
        int lat;
        bus.op       = MUL_;
        bus.a        = 16'h0003;
        bus.b        = 16'h0005;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.cout, bus.overflow} !==
            {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_mul: got rdy=%b vld=%b res=%h z=%b c=%b v=%b want rdy=1 vld=0 res=0000 z=0 c=0 v=0",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.cout, bus.overflow);
        end
        run_op(ADD_, 16'h0001, 16'h0001, lat);
        total++;
        if ({bus.result, lat} !== {16'h0002, 32'sd1}) begin
            bad++;
            $display("FAIL after_reset_add: got res=%h lat=%0d want res=0002 lat=1", bus.result, lat);
        end
        release_op;
    endtask

    initial begin
        test_reset;
        test_alu_ops;
        test_shift;
        test_mul;
        test_back_to_back;
        test_reset_mid_mul;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_nbit_seq.md
# alu_nbit_seq

Parametrised, registered ALU that replaces the fixed 16-bit combinational ripple ALU in the datapath. It adds a valid/ready handshake, registered result and flags, and a correct signed set-less-than. It also adds two multi-cycle operations: a bit-serial logical shift and a shift-add unsigned multiply. The block sits between the operand registers and the writeback stage. It accepts one operation at a time.

## Interface
Parameters:
- WIDTH, default 16: operand/result width. Must be a power of two, ≥4.
- SW, default $clog2(WIDTH): shift-amount width. Derived; do not override.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 SLL, 110 SRL, 111 MUL.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B. For shifts, only b[SW-1:0] (shamt) is used.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- cout  out  1  carry out of the MSB (ADD/SUB only).
- overflow  out  1  signed overflow for ADD/SUB; unsigned overflow for MUL.

## Operation
- FSM states: IDLE, SHIFT, MUL, DONE.
- Accept occurs when in_valid && in_ready. a, b and op are captured at accept; later input changes are ignored.
- IDLE → DONE on accept of AND, OR, ADD, SUB or SLT. Result and flags are computed from the captured operands and registered at the accept edge.
- IDLE, accept of SLL/SRL:
  - shamt==0 → DONE, result=a.
  - otherwise → SHIFT with cnt=shamt and working register=a.
- SHIFT: each cycle shifts the working register by 1 (zero-fill) and decrements cnt. When cnt reaches 0 → DONE.
- IDLE, accept of MUL → MUL. Product register (2*WIDTH) starts at 0; multiplier = b; multiplicand = a; cnt=WIDTH.
- MUL: each cycle adds the multiplicand (shifted by the iteration index) to the product if the current multiplier LSB is 1, then shifts the multiplier right and decrements cnt. When cnt reaches 0 → DONE.
  - result = product[WIDTH-1:0].
  - overflow = |product[2*WIDTH-1:WIDTH].
- DONE: out_valid=1; result and flags are held stable. When out_ready=1 → IDLE.
- Arithmetic:
  - ADD: a+b.
  - SUB: a+~b+1. cout=1 means no borrow.
  - ADD/SUB overflow = carry into MSB XOR carry out of MSB.
- SLT:
  - result = {0…0, s}, where s = sum_msb(a−b) XOR overflow(a−b). This is correct even when the subtraction overflows.
  - cout=0, overflow=0.
- AND/OR/shift: cout=0, overflow=0. MUL: cout=0.
- zero is computed from the final registered result for every op.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, cout=0, overflow=0, cnt=0. Reset dominates any in-flight SHIFT/MUL/DONE; the pending result is discarded.
- in_ready is a registered-state decode: 1 in IDLE only. There is no combinational path from in_valid to in_ready.
- Latency counts edges from the accept edge to the first cycle with out_valid=1:
  - single-cycle ops: 1.
  - SLL/SRL: max(1, shamt).
  - MUL: WIDTH.
- After an out_valid && out_ready edge, in_ready=1 the next cycle. Peak throughput is one op per 2 cycles.
- out_ready held low: the block stays in DONE indefinitely with outputs unchanged. in_valid is ignored during this time.
- out_ready=1 outside DONE has no effect.
- In-flight shift/MUL ignores in_valid and op changes.

## Test plan
- Reset mid-MUL: WIDTH=16, MUL a=3 b=5, then rst_n=0 at cycle 4 → next cycle out_valid=0, in_ready=1, result=0, all flags 0.
- ADD/SUB flags:
  - ADD 0x7FFF+0x0001 → 1 cycle later out_valid, result=0x8000, overflow=1, cout=0, zero=0.
  - SUB 0x1234−0x1234 → result=0, zero=1, cout=1, overflow=0.
- SLT overflow case: a=0x8000 (−32768), b=0x0001 → result=0x0001. Swapped operands → result=0x0000.
- Shift latency:
  - SLL a=0x0001 shamt=15 → out_valid exactly 15 cycles after accept, result=0x8000.
  - SRL a=0xF000 shamt=0 → 1 cycle, result=0xF000.
- MUL:
  - a=0x0100 b=0x0100 → out_valid after 16 cycles, result=0x0000, zero=1, overflow=1.
  - a=0x00FF b=0x0101 → result=0xFFFF, overflow=0.
- Backpressure: ADD completes with out_ready=0 for 10 cycles while in_valid=1 with new operands → result stable, in_ready=0, no second accept. Raise out_ready → IDLE next cycle, and the new op is accepted on the following edge.
